clock_display_scanner: RTL and testbench

Downstream consumer of the time-of-day counter chain. Takes the binary hours/minutes/seconds counts and drives a six-digit, time-multiplexed, common-anode 7-segment display. It snapshots the counts once per frame so the display never tears, and converts each field to two decimal digits. It also handles leading-zero blanking, out-of-range indication, per-field blink for time-set mode and a toggling colon on the decimal points.

---
 rtl/clock_disp_pkg.sv | 58 +++++
 rtl/seg7_decode.sv | 44 ++++
 rtl/clock_display_scanner.sv | 148 ++++++++++++++
 tb/tb_clock_display_scanner.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_disp_pkg
// Purpose  : Shared constants and helpers for the clock display scanner:
//            active-low 7-segment codes, field indices, field range limits
//            and a binary-to-two-digit-decimal helper.
// Revision : 1.0 - initial release
// ============================================================================
package clock_disp_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Field index = digit index / 2
  localparam logic [1:0] FLD_SEC = 2'd0;
  localparam logic [1:0] FLD_MIN = 2'd1;
  localparam logic [1:0] FLD_HR  = 2'd2;

  localparam logic [4:0] MAX_HR      = 5'd23;
  localparam logic [5:0] MAX_MIN_SEC = 6'd59;

  // Split a 6-bit value (0..63) into {tens, ones} by compare/subtract.
  // Tens can reach 6 for out-of-range values; those are shown as dashes
  // upstream, but the arithmetic is still exact.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 6'd60) begin
      tens = 4'd6; ones = 4'(v - 6'd60);
    end else if (v >= 6'd50) begin
      tens = 4'd5; ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4; ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3; ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2; ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1; ones = 4'(v - 6'd10);
    end else begin
      tens = 4'd0; ones = 4'(v);
    end
    return {tens, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational digit to active-low 7-segment pattern decoder.
// Ports    : digit  in  4  decimal digit 0..9 (others decode to blank)
//            dash   in  1  show a dash instead of the digit
//            blank  in  1  show nothing (overrides dash)
//            seg    out 7  {g,f,e,d,c,b,a}, active-low
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : clock_display_scanner
// Purpose  : Drives a six-digit multiplexed common-anode 7-segment display
//            from binary hh:mm:ss counts. Counts are snapshotted once per
//            frame so a frame never mixes two different times.
// Ports    : clk, reset    clock, synchronous active-high reset
//            hours/minutes/seconds  binary time inputs
//            sec_tick      1 Hz pulse toggling the colon
//            blink_en      per-field blink enable {hr,min,sec}
//            blink_phase   blanks fields with blink_en set while high
//            an            digit anodes, active-low, bit 0 = seconds ones
//            seg           segments {g,f,e,d,c,b,a}, active-low
//            dp            decimal point (colon), active-low
//            frame_start   one-cycle pulse at the start of each frame
// Revision : 1.0 - initial release
// ============================================================================
module clock_display_scanner
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       sec_tick,
  input  logic [2:0] blink_en,
  input  logic       blink_phase,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int              CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_scan_cnt;
  logic [2:0]       r_digit_idx;
  logic [4:0]       r_snap_h;
  logic [5:0]       r_snap_m;
  logic [5:0]       r_snap_s;
  logic             r_colon;

  logic             w_slot_end;
  logic [1:0]       w_field;
  logic [5:0]       w_val;
  logic [7:0]       w_bcd;
  logic [3:0]       w_digit;
  logic             w_oor;
  logic             w_blink;
  logic             w_lz;
  logic             w_an_on;
  logic [5:0]       w_an_next;
  logic [6:0]       w_seg_next;
  logic             w_dp_next;
  logic             w_fs_next;

  assign w_slot_end = (r_scan_cnt == c_cnt_max);

  // Scan position, per-frame snapshot and colon state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 3'd0;
      r_snap_h    <= '0;
      r_snap_m    <= '0;
      r_snap_s    <= '0;
      r_colon     <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_scan_cnt  <= '0;
        r_digit_idx <= (r_digit_idx == 3'd5) ? 3'd0 : r_digit_idx + 3'd1;
        // Entering slot 0: latch a fresh time for the whole frame
        if (r_digit_idx == 3'd5) begin
          r_snap_h <= hours;
          r_snap_m <= minutes;
          r_snap_s <= seconds;
        end
      end else begin
        r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
      if (sec_tick) begin
        r_colon <= ~r_colon;
      end
    end
  end

  // Digit mux: two digits per field, even index = ones, odd = tens
  assign w_field = r_digit_idx[2:1];

  always_comb begin
    w_val = r_snap_s;
    w_oor = (r_snap_s > MAX_MIN_SEC);
    case (w_field)
      FLD_HR: begin
        w_val = {1'b0, r_snap_h};
        w_oor = (r_snap_h > MAX_HR);
      end
      FLD_MIN: begin
        w_val = r_snap_m;
        w_oor = (r_snap_m > MAX_MIN_SEC);
      end
      default: begin
        w_val = r_snap_s;
        w_oor = (r_snap_s > MAX_MIN_SEC);
      end
    endcase
  end

  assign w_bcd   = bin_to_bcd(w_val);
  assign w_digit = r_digit_idx[0] ? w_bcd[7:4] : w_bcd[3:0];

  assign w_blink = blink_phase & blink_en[w_field];
  assign w_lz    = (r_digit_idx == 3'd5) && (r_snap_h < 5'd10);

  // Anode off in the final cycle of each slot so segment changes are hidden
  assign w_an_on   = ~w_slot_end & ~w_blink & ~w_lz;
  assign w_an_next = w_an_on ? ~(6'b000001 << r_digit_idx) : 6'b111111;

  seg7_decode u_seg7_decode (
    .digit (w_digit),
    .dash  (w_oor),
    .blank (w_blink | w_lz),
    .seg   (w_seg_next)
  );

  assign w_dp_next = ~(((r_digit_idx == 3'd2) || (r_digit_idx == 3'd4)) && r_colon);
  assign w_fs_next = (r_digit_idx == 3'd0) && (r_scan_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= 6'b111111;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= w_an_next;
      seg         <= w_seg_next;
      dp          <= w_dp_next;
      frame_start <= w_fs_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_display_scanner
// Purpose  : Self-checking bench for clock_display_scanner (SCAN_DIV = 4).
//            A cycle-level reference model built from the display rules
//            checks every output each cycle; a vector table and hand-written
//            sequences check digit content, snapshot timing, colon and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_display_scanner;

  localparam int SD_DIV = 4;
  localparam int FRAME  = 6 * SD_DIV;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] hours = '0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       sec_tick = 1'b0;
  logic [2:0] blink_en = '0;
  logic       blink_phase = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  clock_display_scanner #(.SCAN_DIV(SD_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .sec_tick    (sec_tick),
    .blink_en    (blink_en),
    .blink_phase (blink_phase),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: position within the frame in cycles, snapshot, colon
  int m_pos = 0, m_h = 0, m_m = 0, m_s = 0;
  bit m_colon = 1'b0;

  // Per-frame capture of the segment pattern seen with each anode on
  bit         cap_seen [6];
  logic [6:0] cap_seg  [6];
  int         dp_low_cnt = 0;
  int         d5_on_cnt  = 0;
  bit         chk_glitch = 1'b0;
  logic [6:0] prev_seg = SB;
  logic [5:0] prev_an  = 6'h3F;

  typedef struct packed {
    logic [4:0]      h;
    logic [5:0]      m;
    logic [5:0]      s;
    logic [2:0]      be;
    logic            bp;
    logic [5:0][6:0] exp;   // index = digit, SB = digit never lit
  } vec_t;

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return S0; 1: return S1; 2: return S2; 3: return S3; 4: return S4;
      5: return S5; 6: return S6; 7: return S7; 8: return S8; 9: return S9;
      default: return SB;
    endcase
  endfunction

  task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cap_clear();
    for (int d = 0; d < 6; d++) begin
      cap_seen[d] = 1'b0;
      cap_seg[d]  = SB;
    end
    dp_low_cnt = 0;
    d5_on_cnt  = 0;
  endtask

  task automatic cap_sample();
    for (int d = 0; d < 6; d++) begin
      if (an == ~(6'b000001 << d)) begin
        cap_seen[d] = 1'b1;
        cap_seg[d]  = seg;
      end
    end
    if (dp == 1'b0) dp_low_cnt++;
    if (an[5] == 1'b0) d5_on_cnt++;
  endtask

  // One clock: predict outputs from the model, clock, advance model, compare
  task automatic step();
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    int slot, fld, val, mx;
    bit last, bl, lz;
    if (reset) begin
      e_an = 6'h3F; e_seg = SB; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      slot = m_pos / SD_DIV;
      last = (m_pos % SD_DIV) == SD_DIV - 1;
      fld  = slot / 2;
      val  = (fld == 2) ? m_h : (fld == 1) ? m_m : m_s;
      mx   = (fld == 2) ? 23 : 59;
      bl   = blink_phase && blink_en[fld];
      lz   = (slot == 5) && (m_h < 10);
      e_an  = (!last && !bl && !lz) ? ~(6'b000001 << slot) : 6'h3F;
      e_seg = (bl || lz) ? SB : (val > mx) ? SD
            : seg_of((slot % 2) ? val / 10 : val % 10);
      e_dp  = ((slot == 2 || slot == 4) && m_colon) ? 1'b0 : 1'b1;
      e_fs  = (m_pos == 0);
    end
    @(posedge clk);
    if (reset) begin
      m_pos = 0; m_h = 0; m_m = 0; m_s = 0; m_colon = 1'b0;
    end else begin
      if (m_pos == FRAME - 1) begin
        m_h = int'(hours); m_m = int'(minutes); m_s = int'(seconds);
      end
      m_pos = (m_pos + 1) % FRAME;
      if (sec_tick) m_colon = ~m_colon;
    end
    #1;
    chk("an", {1'b0, an}, {1'b0, e_an});
    chk("seg", seg, e_seg);
    chk("dp", {6'b0, dp}, {6'b0, e_dp});
    chk("frame_start", {6'b0, frame_start}, {6'b0, e_fs});
    if (chk_glitch && seg !== prev_seg)
      chk("seg_change_anode_off", {1'b0, prev_an}, 7'h3F);
    prev_seg = seg;
    prev_an  = an;
    cap_sample();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until frame_start is observed, with a bounded wait
  task automatic sync_frame();
    int k = 0;
    while (frame_start !== 1'b1 && k < FRAME + 6) begin
      step();
      k++;
    end
    if (frame_start !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL sync_frame: frame_start not seen within %0d cycles", k);
    end
  endtask

  task automatic set_time(int h, int m, int s);
    hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{h:5'd13, m:6'd45, s:6'd27, be:3'b000, bp:1'b0, exp:{S1, S3, S4, S5, S2, S7}};
    vecs[1] = '{h:5'd24, m:6'd60, s:6'd05, be:3'b000, bp:1'b0, exp:{SD, SD, SD, SD, S0, S5}};
    vecs[2] = '{h:5'd09, m:6'd05, s:6'd00, be:3'b000, bp:1'b0, exp:{SB, S9, S0, S5, S0, S0}};
    vecs[3] = '{h:5'd10, m:6'd20, s:6'd30, be:3'b010, bp:1'b1, exp:{S1, S0, SB, SB, S3, S0}};
    vecs[4] = '{h:5'd23, m:6'd59, s:6'd59, be:3'b000, bp:1'b0, exp:{S2, S3, S5, S9, S5, S9}};
    vecs[5] = '{h:5'd08, m:6'd63, s:6'd60, be:3'b000, bp:1'b0, exp:{SB, S8, SD, SD, SD, SD}};
    vecs[6] = '{h:5'd17, m:6'd38, s:6'd42, be:3'b101, bp:1'b1, exp:{SB, SB, S3, S8, SB, SB}};

    cap_clear();

    // Reset, then idle with zero inputs
    steps(4);
    chk("reset_an", {1'b0, an}, 7'h3F);
    chk("reset_seg", seg, SB);
    reset = 1'b0;
    step();
    chk("first_frame_start", {6'b0, frame_start}, 7'd1);
    cap_clear();
    steps(2 * FRAME);
    chk("idle_digit5_never_on", 7'(d5_on_cnt), 7'd0);

    // Vector table: load inputs, let one frame pick them up, check the next
    for (int v = 0; v < 7; v++) begin
      set_time(int'(vecs[v].h), int'(vecs[v].m), int'(vecs[v].s));
      blink_en    = vecs[v].be;
      blink_phase = vecs[v].bp;
      steps(FRAME);
      sync_frame();
      cap_clear();
      cap_sample();
      steps(FRAME - 1);
      for (int d = 0; d < 6; d++)
        chk($sformatf("vec%0d_digit%0d", v, d),
            cap_seen[d] ? cap_seg[d] : SB, vecs[v].exp[d]);
    end
    blink_en = 3'b000;
    blink_phase = 1'b0;

    // Slot timing with stable inputs: segments only change behind a dark anode
    set_time(13, 45, 27);
    steps(FRAME);
    chk_glitch = 1'b1;
    steps(2 * FRAME);
    chk_glitch = 1'b0;

    // Inputs change in slot 3: rest of the frame keeps the old time
    set_time(10, 20, 30);
    steps(FRAME);
    sync_frame();
    steps(3 * SD_DIV);
    set_time(11, 21, 31);
    cap_clear();
    cap_sample();
    steps(3 * SD_DIV - 1);
    chk("midframe_d3_old", cap_seg[3], S2);
    chk("midframe_d4_old", cap_seg[4], S0);
    chk("midframe_d5_old", cap_seg[5], S1);
    cap_clear();
    steps(FRAME);
    chk("next_frame_d0_new", cap_seg[0], S1);
    chk("next_frame_d2_new", cap_seg[2], S1);
    chk("next_frame_d4_new", cap_seg[4], S1);

    // Blink minutes plus colon toggling
    blink_en = 3'b010;
    blink_phase = 1'b1;
    steps(FRAME);
    cap_clear();
    steps(FRAME);
    chk("blink_d2_dark", {6'b0, cap_seen[2]}, 7'd0);
    chk("blink_d3_dark", {6'b0, cap_seen[3]}, 7'd0);
    chk("colon_off_initially", 7'(dp_low_cnt), 7'd0);
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
    steps(FRAME);
    cap_clear();
    steps(FRAME);
    chk("colon_on_dp_cycles", 7'(dp_low_cnt), 7'(2 * SD_DIV));
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
    steps(FRAME);
    cap_clear();
    steps(FRAME);
    chk("colon_off_again", 7'(dp_low_cnt), 7'd0);
    blink_en = 3'b000;
    blink_phase = 1'b0;

    // Reset in the middle of a frame
    steps(10);
    reset = 1'b1;
    step();
    chk("midreset_an", {1'b0, an}, 7'h3F);
    chk("midreset_fs", {6'b0, frame_start}, 7'd0);
    reset = 1'b0;
    step();
    chk("midreset_restart_fs", {6'b0, frame_start}, 7'd1);

    // Randomized inputs against the reference model
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      sec_tick    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) blink_en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) blink_phase = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    sec_tick = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
